// File: rtl/led_panel_pkg.sv
// Shared types and defaults for the LED panel binary-coded-modulation scan driver.
package led_panel_pkg;

  localparam int DEF_COLS      = 64;
  localparam int DEF_ROW_BITS  = 5;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_BASE_HOLD = 64;

  typedef enum logic [2:0] {
    FIRSTCOL,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    UNBLANK,
    HOLD,
    NEXT
  } bcm_state_t;

  // Unblank time doubles with each bit-plane, giving the binary weighting.
  function automatic int unsigned hold_len(input int unsigned base, input int unsigned plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// Unblank hold counter: load clears the count and captures the terminal value.
module led_bcm_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;
  logic [W-1:0] term_q;

  // Counting stops at the terminal value so the count never runs past its bound.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      term_q <= '0;
    end else if (load) begin
      count  <= '0;
      term_q <= term;
    end else if (run && !tc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == term_q);

endmodule

// File: rtl/led_panel_bcm.sv
// HUB75-style row scanner with binary-coded modulation across DEPTH bit-planes.
// Optional second colour channel for dual-scan panels: define LED_PANEL_DUAL_SCAN_EN.
module led_panel_bcm
  import led_panel_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_HOLD = DEF_BASE_HOLD,
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PLANE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROW_BITS-1:0] rows_in,
  output logic [COL_W-1:0]    pix_col,
  output logic [ROW_BITS-1:0] pix_row,
  output logic [PLANE_W-1:0]  pix_plane,
  input  logic [2:0]          pix_rgb,
`ifdef LED_PANEL_DUAL_SCAN_EN
  input  logic [2:0]          pix_rgb2,
  output logic                red2_out,
  output logic                green2_out,
  output logic                blue2_out,
`endif
  output logic                red_out,
  output logic                green_out,
  output logic                blue_out,
  output logic                sclk_out,
  output logic                latch_out,
  output logic                blank_out,
  output logic                aclk_out,
  output logic                arst_out,
  output logic [ROW_BITS-1:0] row_addr_out
);

  localparam int HOLD_MAX = hold_len(BASE_HOLD, DEPTH - 1);
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  bcm_state_t          state, next_state;
  logic [COL_W-1:0]    col;
  logic [ROW_BITS-1:0] row;
  logic [PLANE_W-1:0]  plane;
  logic [HOLD_W-1:0]   hold_term;
  logic                hold_tc;

  // HOLD covers all but one clock of the plane's unblank time; UNBLANK supplies the other.
  assign hold_term = HOLD_W'(hold_len(BASE_HOLD, 32'(plane)) - 32'd2);

  led_bcm_timer #(.W(HOLD_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state == UNBLANK),
    .run   (state == HOLD),
    .term  (hold_term),
    .tc    (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= FIRSTCOL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FIRSTCOL: next_state = SHIFT_LO;
      SHIFT_LO: next_state = SHIFT_HI;
      SHIFT_HI: next_state = (col == COL_W'(COLS - 1)) ? LATCH : SHIFT_LO;
      LATCH:    next_state = UNBLANK;
      UNBLANK:  next_state = HOLD;
      HOLD:     if (hold_tc) next_state = NEXT;
      NEXT:     next_state = FIRSTCOL;
      default:  next_state = FIRSTCOL;
    endcase
  end

  // Each state's output values appear on the clock after that state, so data leads sclk by one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      plane     <= '0;
      red_out   <= 1'b0;
      green_out <= 1'b0;
      blue_out  <= 1'b0;
`ifdef LED_PANEL_DUAL_SCAN_EN
      red2_out   <= 1'b0;
      green2_out <= 1'b0;
      blue2_out  <= 1'b0;
`endif
      sclk_out  <= 1'b0;
      latch_out <= 1'b1;
      blank_out <= 1'b1;
      aclk_out  <= 1'b0;
      arst_out  <= 1'b1;
    end else begin
      aclk_out <= 1'b0;
      arst_out <= 1'b0;
      case (state)
        FIRSTCOL: begin
          blank_out <= 1'b1;
          latch_out <= 1'b1;
          sclk_out  <= 1'b0;
          col       <= '0;
        end
        SHIFT_LO: begin
          sclk_out <= 1'b0;
          {red_out, green_out, blue_out} <= pix_rgb;
`ifdef LED_PANEL_DUAL_SCAN_EN
          {red2_out, green2_out, blue2_out} <= pix_rgb2;
`endif
        end
        SHIFT_HI: begin
          sclk_out <= 1'b1;
          if (col != COL_W'(COLS - 1)) col <= col + COL_W'(1);
        end
        LATCH: begin
          sclk_out  <= 1'b0;
          latch_out <= 1'b0;
        end
        UNBLANK: begin
          latch_out <= 1'b1;
          blank_out <= 1'b0;
        end
        HOLD: begin
        end
        NEXT: begin
          blank_out <= 1'b1;
          if (plane != PLANE_W'(DEPTH - 1)) begin
            plane <= plane + PLANE_W'(1);
          end else begin
            plane <= '0;
            // A >= compare lets a lowered rows_in take effect on the very next advance.
            if (row >= rows_in) begin
              row      <= '0;
              arst_out <= 1'b1;
            end else begin
              row      <= row + ROW_BITS'(1);
              aclk_out <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pix_col      = col;
  assign pix_row      = row;
  assign pix_plane    = plane;
  assign row_addr_out = row;

endmodule

// File: tb/tb_led_panel_bcm.sv
// Scoreboard bench for led_panel_bcm: a frame model queues the expected shift/latch/blank/row events.
module tb_led_panel_bcm;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 2;
  localparam int DEPTH     = 2;
  localparam int BASE_HOLD = 4;
  localparam int NROWS     = 1 << ROW_BITS;
  localparam int TIMEOUT   = 3000;

  typedef enum int {EV_SHIFT, EV_LATCH, EV_BLANK, EV_ROW} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  rin_plan[$];
  int  total = 0;
  int  bad   = 0;
  int  edge_count = 0;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [ROW_BITS-1:0] rows_in;
  logic [1:0]          pix_col;
  logic [ROW_BITS-1:0] pix_row;
  logic [0:0]          pix_plane;
  logic [2:0]          pix_rgb;
  logic                red_out, green_out, blue_out;
  logic                sclk_out, latch_out, blank_out, aclk_out, arst_out;
  logic [ROW_BITS-1:0] row_addr_out;
  logic [2:0]          img  [NROWS][DEPTH][COLS];
  logic [2:0]          img2 [NROWS][DEPTH][COLS];
`ifdef LED_PANEL_DUAL_SCAN_EN
  logic [2:0]          pix_rgb2;
  logic                red2_out, green2_out, blue2_out;
  assign pix_rgb2 = img2[pix_row][pix_plane][pix_col];
`endif

  assign pix_rgb = img[pix_row][pix_plane][pix_col];

  always #5 clk = ~clk;

  led_panel_bcm #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_HOLD(BASE_HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rows_in      (rows_in),
    .pix_col      (pix_col),
    .pix_row      (pix_row),
    .pix_plane    (pix_plane),
    .pix_rgb      (pix_rgb),
`ifdef LED_PANEL_DUAL_SCAN_EN
    .pix_rgb2     (pix_rgb2),
    .red2_out     (red2_out),
    .green2_out   (green2_out),
    .blue2_out    (blue2_out),
`endif
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .sclk_out     (sclk_out),
    .latch_out    (latch_out),
    .blank_out    (blank_out),
    .aclk_out     (aclk_out),
    .arst_out     (arst_out),
    .row_addr_out (row_addr_out)
  );

  task automatic checkOutput(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  function automatic int pixel_word(input int r, input int p, input int c);
`ifdef LED_PANEL_DUAL_SCAN_EN
    return int'({img2[r][p][c], img[r][p][c]});
`else
    return int'(img[r][p][c]);
`endif
  endfunction

  function automatic void push_exp(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Frame model: per plane COLS shifts, one latch, a blank-low window of BASE_HOLD<<p,
  // then a row event carrying {arst, new row, clocks since previous row event}.
  task automatic model_run(input int n_adv);
    int row, nrow, arst, period;
    row = 0;
    for (int k = 0; k < n_adv; k++) begin
      period = 0;
      for (int p = 0; p < DEPTH; p++) begin
        for (int c = 0; c < COLS; c++) push_exp(EV_SHIFT, pixel_word(row, p, c));
        push_exp(EV_LATCH, 1);
        push_exp(EV_BLANK, BASE_HOLD << p);
        period += 2 * COLS + 3 + (BASE_HOLD << p);
      end
      if (row >= rin_plan[k]) begin
        nrow = 0;
        arst = 1;
      end else begin
        nrow = row + 1;
        arst = 0;
      end
      push_exp(EV_ROW, arst * 100000 + nrow * 1000 + period);
      row = nrow;
    end
  endtask

  task automatic fill_image(input bit rnd, input logic [2:0] v, input logic [2:0] v2);
    for (int r = 0; r < NROWS; r++)
      for (int p = 0; p < DEPTH; p++)
        for (int c = 0; c < COLS; c++) begin
          img[r][p][c]  = rnd ? 3'($urandom_range(0, 7)) : v;
          img2[r][p][c] = rnd ? 3'($urandom_range(0, 7)) : v2;
        end
  endtask

  task automatic set_plan(input int n, input int rin);
    rin_plan.delete();
    for (int i = 0; i < n; i++) rin_plan.push_back(rin);
  endtask

  // Monitor side of the scoreboard.
  task automatic observe(input ev_kind_t k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput({"unexpected_", k.name()}, v, -1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({k.name(), "_kind"}, int'(k), int'(e.kind));
      checkOutput(k.name(), v, e.val);
    end
  endtask

  always @(posedge clk) edge_count <= reset ? edge_count + 1 : 0;

  logic prev_sclk, prev_latch, prev_blank;
  int   latch_w, blank_w, last_row_t;

  always @(negedge clk) begin
    if (!reset) begin
      prev_sclk  = 1'b0;
      prev_latch = 1'b1;
      prev_blank = 1'b1;
      latch_w    = 0;
      blank_w    = 0;
      last_row_t = 0;
    end else begin
      if (sclk_out && !prev_sclk) begin
`ifdef LED_PANEL_DUAL_SCAN_EN
        observe(EV_SHIFT, int'({red2_out, green2_out, blue2_out, red_out, green_out, blue_out}));
`else
        observe(EV_SHIFT, int'({red_out, green_out, blue_out}));
`endif
      end
      if (!latch_out) latch_w++;
      else if (!prev_latch) begin
        observe(EV_LATCH, latch_w);
        latch_w = 0;
      end
      if (!blank_out) blank_w++;
      else if (!prev_blank) begin
        observe(EV_BLANK, blank_w);
        blank_w = 0;
      end
      if (aclk_out || arst_out) begin
        observe(EV_ROW, int'(arst_out) * 100000 + int'(row_addr_out) * 1000 + (edge_count - last_row_t));
        last_row_t = edge_count;
      end
      prev_sclk  = sclk_out;
      prev_latch = latch_out;
      prev_blank = blank_out;
    end
  end

  task automatic do_reset(input int n, input string nm);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    checkOutput({nm, "_blank"}, int'(blank_out), 1);
    checkOutput({nm, "_latch"}, int'(latch_out), 1);
    checkOutput({nm, "_arst"}, int'(arst_out), 1);
    checkOutput({nm, "_aclk"}, int'(aclk_out), 0);
    checkOutput({nm, "_sclk"}, int'(sclk_out), 0);
    checkOutput({nm, "_rgb"}, int'({red_out, green_out, blue_out}), 0);
    checkOutput({nm, "_row"}, int'(row_addr_out), 0);
    checkOutput({nm, "_col_plane"}, int'({pix_col, pix_plane}), 0);
  endtask

  task automatic applyStimulus(input int n_adv);
    model_run(n_adv);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 checkOutput("arst_before_first_edge", int'(arst_out), 1);
    @(posedge clk);
    #1 checkOutput("arst_after_release", int'(arst_out), 0);
    checkOutput("blank_after_release", int'(blank_out), 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput({nm, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(row_addr_out) != r && n < TIMEOUT);
    checkOutput("wait_row_reached", int'(row_addr_out), r);
  endtask

  task automatic wait_blank_low();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (blank_out && n < TIMEOUT);
    checkOutput("wait_blank_low", int'(blank_out), 0);
  endtask

  initial begin
    rows_in = 2'd3;
    fill_image(1'b0, 3'b101, 3'b010);
    do_reset(3, "reset_initial");
    set_plan(4, 3);
    applyStimulus(4);
    drain("frame_const");

    $display("[TB] random image, random rows_in");
    do_reset(2, "reset_rand");
    fill_image(1'b1, 3'b000, 3'b000);
    rows_in = ROW_BITS'($urandom_range(0, 3));
    set_plan(6, int'(rows_in));
    applyStimulus(6);
    drain("frame_rand");

    $display("[TB] rows_in lowered while on row 2");
    do_reset(2, "reset_rows");
    fill_image(1'b1, 3'b000, 3'b000);
    rows_in = 2'd3;
    rin_plan.delete();
    rin_plan = '{3, 3, 1, 1, 1};
    applyStimulus(5);
    wait_row(2);
    #1 rows_in = 2'd1;
    drain("rows_change");

    $display("[TB] reset during hold");
    do_reset(2, "reset_pre_hold");
    fill_image(1'b1, 3'b000, 3'b000);
    rows_in = 2'd3;
    set_plan(4, 3);
    applyStimulus(4);
    wait_row(1);
    wait_blank_low();
    do_reset(1, "reset_in_hold");
    repeat (2) @(posedge clk);
    set_plan(4, 3);
    applyStimulus(4);
    drain("after_hold_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_panel_bcm.md
LED_PANEL_BCM -- requirements
Module: led_panel_bcm

Interface
REQ-001 Parameters: COLS, 64, columns shifted per row; ROW_BITS, 5, row counter width; DEPTH, 4, bit-planes per colour (binary-coded modulation); BASE_HOLD, 64, unblank clocks for plane 0 (>=2).
REQ-002 clk  in  1  clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low.
REQ-004 rows_in  in  ROW_BITS  index of last scanned row (row count minus 1).
REQ-005 pix_col  out  clog2(COLS)  pixel column request; pix_row  out  ROW_BITS; pix_plane  out  clog2(DEPTH); all driven combinationally from internal counters.
REQ-006 pix_rgb  in  3  {r,g,b} bit of the requested plane, valid in the same cycle as the request.
REQ-007 red_out, green_out, blue_out  out  1 each  registered serial colour data.
REQ-008 sclk_out  out  1  shift clock; latch_out  out  1  active-low latch; blank_out  out  1  active-high blank.
REQ-009 aclk_out  out  1  row-advance pulse; arst_out  out  1  row-reset pulse; row_addr_out  out  ROW_BITS  direct row address (= row counter).

Function
REQ-010 All outputs registered; states FIRSTCOL, SHIFT_LO, SHIFT_HI, LATCH, UNBLANK, HOLD, NEXT.
REQ-011 FIRSTCOL (1 clk): blank=1, latch=1, sclk=0, aclk=0, arst=0, col=0 -> SHIFT_LO.
REQ-012 SHIFT_LO: sclk=0, colour outputs <= pix_rgb -> SHIFT_HI.
REQ-013 SHIFT_HI: sclk=1; if col==COLS-1 -> LATCH, else col++ -> SHIFT_LO; exactly COLS sclk rising edges per plane.
REQ-014 LATCH: sclk=0, latch=0 -> UNBLANK.
REQ-015 UNBLANK: latch=1, blank=0, hold counter=0 -> HOLD.
REQ-016 HOLD: lasts (BASE_HOLD<<plane)-1 clocks -> NEXT; blank_out low for exactly BASE_HOLD<<plane clocks per plane.
REQ-017 NEXT: blank=1; if plane<DEPTH-1 plane++, row unchanged; else plane=0 and row advances -> FIRSTCOL.
REQ-018 Row advance: if row>=rows_in then row=0, arst=1 for one clock; else row++, aclk=1 for one clock.
REQ-019 rows_in sampled only in NEXT; lowering it mid-frame wraps at the next row advance (>= compare).
REQ-020 Clocks per plane p = 2*COLS+3+(BASE_HOLD<<p).
REQ-021 Counter wrap: col, plane, hold counters never exceed their bounds; no overflow states.

Reset
REQ-022 While reset=0: state=FIRSTCOL, colours=0, blank=1, latch=1, sclk=0, aclk=0, arst=1, col=row=plane=hold=0.
REQ-023 Reset asserted mid-operation aborts immediately to REQ-022 values; first FIRSTCOL on first clock after release.

Configuration
REQ-024 Macro LED_PANEL_DUAL_SCAN_EN defined: adds pix_rgb2 in 3 and red2_out, green2_out, blue2_out out 1, loaded in SHIFT_LO alongside primary channel, reset 0.
REQ-025 Macro undefined: those ports and registers absent; all other behaviour identical.

Structure
REQ-026 Package led_panel_pkg: state enum, default parameter constants, hold-length function BASE_HOLD<<plane.
REQ-027 One sub-module led_bcm_timer: hold counter with load/start, terminal-count output; all else in led_panel_bcm.

Verification (COLS=4, ROW_BITS=2, DEPTH=2, BASE_HOLD=4, rows_in=3)
REQ-028 Reset low 3 clks -> blank=1, latch=1, arst=1, sclk=0, colours 0; release -> arst low after 1 clk.
REQ-029 pix_rgb=3'b101 constant -> 4 sclk rising edges per plane, red=1 green=0 blue=1 at each edge, one latch low pulse after last edge.
REQ-030 Plane timing -> blank low 4 clks plane 0, 8 clks plane 1; plane 0 period 15 clks, plane 1 period 19 clks.
REQ-031 Full frame -> aclk pulses 3 times then one arst pulse; row_addr_out 0,1,2,3,0; frame = 136 clks.
REQ-032 rows_in changed 3->1 while row=2 -> next advance wraps to 0 with arst pulse.
REQ-033 Reset asserted during HOLD -> next clock blank=1, state FIRSTCOL after release, row=0; with LED_PANEL_DUAL_SCAN_EN, pix_rgb2=3'b010 -> green2_out=1 at each sclk edge.
